// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the MAR/MDR memory interface.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 9;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_DEPTH  = 512;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } mem_state_e;

endpackage

// File: rtl/ram_sync.sv
// Single-port RAM: synchronous write, registered one-cycle read.
module ram_sync #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array: contents must survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR memory front end: edge-triggered read/write FSM around ram_sync.
module mem_interface
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned DEPTH  = MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mari,
    input  logic              mdri,
    input  logic              mdro,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] bus_out,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              mem_done,
    output logic              req_err
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_d;
    logic [DATA_W-1:0] mdr_d;
    logic              req_err_d;
    logic              rd_prev_q, wr_prev_q;
    logic              rd_edge, wr_edge;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign rd_edge  = mem_read  & ~rd_prev_q;
    assign wr_edge  = mem_write & ~wr_prev_q;
    assign busy     = (state_q == RD_ADDR) || (state_q == RD_DATA) || (state_q == WR);
    assign mem_done = (state_q == DONE);
    assign bus_out  = mdro ? mdr_q : '0;
    // Gate with reset so a reset landing on the WR edge aborts the store.
    assign ram_we   = (state_q == WR) && !reset;

    always_comb begin
        state_d   = state_q;
        req_err_d = req_err;
        case (state_q)
            IDLE: begin
                if (rd_edge && wr_edge) begin
                    req_err_d = 1'b1;
                end else if (rd_edge) begin
                    state_d = RD_ADDR;
                end else if (wr_edge) begin
                    state_d = WR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && (rd_edge || wr_edge)) begin
            req_err_d = 1'b1;
        end
    end

    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (mari && !busy) begin
            mar_d = bus_in[ADDR_W-1:0];
        end
        // RAM data wins over the bus while a read is landing.
        if (state_q == RD_DATA) begin
            if (mdri) begin
                mdr_d = ram_rdata;
            end
        end else if (mdri && !busy) begin
            mdr_d = bus_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            req_err   <= 1'b0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            req_err   <= req_err_d;
            rd_prev_q <= mem_read;
            wr_prev_q <= mem_write;
        end
    end

    ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .addr_i  (mar_q),
        .wdata_i (mdr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, MAR/RAM address width; DATA_W, default 32, bus/MDR/RAM word width; DEPTH, default 512, RAM words.
REQ-002 Ports SHALL be, one per line:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- bus_in  input  DATA_W  shared datapath bus value
- mari  input  1  load MAR from bus_in
- mdri  input  1  load MDR (from bus_in, or from RAM during a read)
- mdro  input  1  drive MDR onto bus_out
- mem_read  input  1  read request, level from control
- mem_write  input  1  write request, level from control
- bus_out  output  DATA_W  MDR when mdro=1, else 0
- mar_q  output  ADDR_W  current MAR
- mdr_q  output  DATA_W  current MDR
- busy  output  1  high while an access is in flight
- mem_done  output  1  one-cycle pulse on access completion
- req_err  output  1  sticky: illegal/dropped request seen
REQ-003 Clock and reset SHALL be one clock, reset synchronous and active-high; ports named clock and reset.

Function
REQ-004 mari=1: MAR <= bus_in[ADDR_W-1:0] next edge; upper bus bits ignored; highest address is DEPTH-1 (511), with no wrap logic beyond truncation.
REQ-005 mdri=1 with no read in progress: MDR <= bus_in next edge.
REQ-006 Requests SHALL be rising-edge detected: a request starts only when mem_read/mem_write is 1 now, was 0 last cycle, and the FSM is IDLE.
REQ-007 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR, DONE.
REQ-008 Read: IDLE -> RD_ADDR (RAM address = MAR) -> RD_DATA (RAM output valid; MDR <= RAM[MAR] if mdri=1, else MDR unchanged) -> DONE -> IDLE.
REQ-009 Write: IDLE -> WR (RAM[MAR] <= MDR) -> DONE -> IDLE.
REQ-010 busy SHALL be 1 in RD_ADDR, RD_DATA and WR; mem_done SHALL be 1 only in DONE. Read latency is 3 cycles from request edge to mem_done; write latency is 2 cycles.
REQ-011 Simultaneous rising edges of mem_read and mem_write SHALL start no access, SHALL set req_err, and SHALL leave the FSM in IDLE.
REQ-012 A request edge arriving while not IDLE SHALL be dropped and SHALL set req_err. A level still high after completion SHALL NOT retrigger.
REQ-013 mari during busy SHALL be ignored (MAR frozen); bus_in mdri during busy SHALL be ignored, and the RAM load in RD_DATA has priority.
REQ-014 bus_out SHALL be combinational: mdro ? MDR : 0.

Reset
REQ-015 reset=1 at an edge SHALL give: FSM IDLE, MAR=0, MDR=0, busy=0, mem_done=0, req_err=0, edge-detect history=0; reset has priority over all inputs.
REQ-016 Reset mid-access SHALL abort it: a write in WR state is suppressed, and RAM contents SHALL NOT be cleared.

Structure
REQ-017 Shared package mem_pkg SHALL hold ADDR_W, DATA_W, DEPTH defaults and the FSM state encoding (3-bit).
REQ-018 RAM SHALL be a sub-module ram_sync (DEPTH x DATA_W, synchronous write, registered 1-cycle read, optional init file); the top level holds MAR, MDR, FSM and edge detect.

Verification
REQ-019 Write/read: MAR<=0x005, MDR<=0x1234ABCD, pulse mem_write -> mem_done at +2 cycles; clear MDR, mem_read+mdri -> mem_done at +3 cycles, mdr_q=0x1234ABCD.
REQ-020 Truncation: bus_in=0xFFFFF3FF with mari -> mar_q=0x1FF; write/read at 0x1FF round-trips.
REQ-021 Conflict: mem_read and mem_write rise together -> no busy, req_err=1, RAM unchanged.
REQ-022 Overlap: mem_write rises during read busy -> dropped, req_err=1, read still returns correct data; a held mem_read level produces exactly one mem_done.
REQ-023 Reset in WR: reset asserted on the WR-state edge -> location keeps its old value, all outputs at reset values next cycle.
REQ-024 bus_out: mdro=0 -> 0; mdro=1 -> MDR value in the same cycle.
